// File: rtl/johnson_counter_param.sv
// Parametrised bidirectional Johnson (twisted-ring) counter.
// A WIDTH-bit ring walks through 2*WIDTH states. The block also provides
// enable, direction select, synchronous load with legality checking,
// self-correction out of illegal states, a decoded phase index and a
// registered wrap pulse.
module johnson_counter_param #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [PW-1:0]    phase,
  output logic             wrap,
  output logic             illegal,
  output logic             load_err
);

  // A Johnson code has at most one boundary between adjacent bits, so it
  // reads as a single run of ones followed by zeros, or the reverse.
  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    int unsigned edges;
    edges = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (v[i+1] != v[i]) edges++;
    end
    return (edges <= 1);
  endfunction

  function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) cnt++;
    end
    return cnt;
  endfunction

  // The forward step from this code lands on the all-zero code.
  localparam logic [WIDTH-1:0] LAST_FWD = WIDTH'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             illegal_c;
  logic [PW-1:0]    phase_c;
  logic [WIDTH-1:0] fwd_step, rev_step;

  assign fwd_step = {~out_q[0], out_q[WIDTH-1:1]};
  assign rev_step = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};

  // Legality check and phase decode, both straight from the ring register.
  always_comb begin
    illegal_c = ~is_legal(out_q);
    phase_c   = '0;
    if (!illegal_c) begin
      if (out_q[WIDTH-1] || (out_q == '0)) begin
        phase_c = PW'(popcount(out_q));
      end else begin
        phase_c = PW'(2 * WIDTH - popcount(out_q));
      end
    end
  end

  // Next-state selection: load beats self-correction beats stepping beats hold.
  always_comb begin
    out_d      = out_q;
    wrap_d     = 1'b0;
    load_err_d = load_err_q;
    if (load) begin
      if (is_legal(load_val)) begin
        out_d = load_val;
      end else begin
        out_d      = '0;
        load_err_d = 1'b1;
      end
    end else if (en && illegal_c) begin
      out_d = '0;
    end else if (en) begin
      if (dir) begin
        out_d  = rev_step;
        wrap_d = (out_q == '0);
      end else begin
        out_d  = fwd_step;
        wrap_d = (out_q == LAST_FWD);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q      <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign out      = out_q;
  assign phase    = phase_c;
  assign wrap     = wrap_q;
  assign illegal  = illegal_c;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed testbench for johnson_counter_param at WIDTH=4.
module tb_johnson_counter_param;

  logic       clk;
  logic       reset;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] out;
  logic [2:0] phase;
  logic       wrap;
  logic       illegal;
  logic       load_err;

  int total;
  int bad;

  // Forward sequence indexed by phase.
  logic [3:0] seq [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                          4'b1111, 4'b0111, 4'b0011, 4'b0001};

  johnson_counter_param #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .out      (out),
    .phase    (phase),
    .wrap     (wrap),
    .illegal  (illegal),
    .load_err (load_err)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive controls, take one clock, then settle just past the edge.
  task automatic applyStimulus(input logic e, input logic d, input logic l,
                               input logic [3:0] lv);
    en       = e;
    dir      = d;
    load     = l;
    load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [3:0] eOut,
                            input logic [2:0] ePhase, input logic eWrap);
    checkOutput({tag, ".out"},   32'(out),   32'(eOut));
    checkOutput({tag, ".phase"}, 32'(phase), 32'(ePhase));
    checkOutput({tag, ".wrap"},  32'(wrap),  32'(eWrap));
  endtask

  logic [3:0] fwdOut   [9] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111,
                               4'b0011, 4'b0001, 4'b0000, 4'b1000};
  logic [2:0] fwdPhase [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  logic       fwdWrap  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    en       = 1'b0;
    dir      = 1'b0;
    load     = 1'b0;
    load_val = 4'b0000;

    // Reset state
    #12;
    checkState("reset", 4'b0000, 3'd0, 1'b0);
    checkOutput("reset.illegal",  32'(illegal),  32'd0);
    checkOutput("reset.load_err", 32'(load_err), 32'd0);
    reset = 1'b1;
    #1;

    // Forward count through a full period and one more step
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
      checkState($sformatf("fwd%0d", k), fwdOut[k], fwdPhase[k], fwdWrap[k]);
    end

    // Load zero, then count backwards
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
    checkState("ld0", 4'b0000, 3'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
    checkState("rev0", 4'b0001, 3'd7, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
    checkState("rev1", 4'b0011, 3'd6, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
    checkState("rev2", 4'b0111, 3'd5, 1'b0);

    // Direction toggle without dead cycles, then hold
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1110);
    checkState("ld1110", 4'b1110, 3'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
    checkState("tog_rev", 4'b1100, 3'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    checkState("tog_fwd", 4'b1110, 3'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
      checkState($sformatf("hold%0d", k), 4'b1110, 3'd3, 1'b0);
    end

    // Legal load overrides en/dir; illegal load clears and sets sticky error
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b0111);
    checkState("ld0111", 4'b0111, 3'd5, 1'b0);
    checkOutput("ld0111.load_err", 32'(load_err), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'b0101);
    checkState("ld0101", 4'b0000, 3'd0, 1'b0);
    checkOutput("ld0101.load_err", 32'(load_err), 32'd1);
    checkOutput("ld0101.illegal",  32'(illegal),  32'd0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
      checkOutput($sformatf("sticky%0d.out", k), 32'(out), 32'(seq[k % 8]));
      checkOutput($sformatf("sticky%0d.wrap", k), 32'(wrap), 32'((k % 8) == 0));
      checkOutput($sformatf("sticky%0d.load_err", k), 32'(load_err), 32'd1);
    end

    // Forced illegal state holds while disabled, self-corrects when enabled
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    checkOutput("pre_force.out", 32'(out), 32'b1111);
    force dut.out_q = 4'b1010;
    #1;
    checkOutput("force.out",     32'(out),     32'b1010);
    checkOutput("force.illegal", 32'(illegal), 32'd1);
    checkOutput("force.phase",   32'(phase),   32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    release dut.out_q;
    #1;
    checkOutput("ill_hold.out",     32'(out),     32'b1010);
    checkOutput("ill_hold.illegal", 32'(illegal), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
    checkState("ill_fix", 4'b0000, 3'd0, 1'b0);
    checkOutput("ill_fix.illegal", 32'(illegal), 32'd0);

    // Asynchronous reset mid-count, then restart from zero
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b1111);
    checkOutput("pre_rst.out",      32'(out),      32'b1111);
    checkOutput("pre_rst.load_err", 32'(load_err), 32'd1);
    load = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkState("async_rst", 4'b0000, 3'd0, 1'b0);
    checkOutput("async_rst.load_err", 32'(load_err), 32'd0);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkState("post_rst", 4'b1000, 3'd1, 1'b0);
    checkOutput("post_rst.load_err", 32'(load_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
